ixc_skid_stage: RTL and testbench
=================================

# ixc_skid_stage

Registered two-entry valid/ready skid stage for wide emulation buses, sitting directly upstream of the `ixc_assign_*` per-bit assign templates. It drives their `R` bus (default 263 bits) from a handshaked producer. It breaks the combinational ready path and registers the data path. Full throughput is one word per clock with no bubbles.

## Interface
Parameters:
- `DATA_W`, 263, payload width; must match the downstream assign template width; legal range 1..4096.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer offers `in_data`.
- `in_ready` output 1: stage accepts when high; registered output.
- `in_data` input DATA_W: payload.
- `in_par` input 1: even-parity bit over `in_data`. Present only with `IXC_SKID_PARITY_EN`.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts.
- `out_data` output DATA_W: payload. Connects to `R` of `ixc_assign_<DATA_W>`.
- `occ` output 2: words held (0, 1 or 2).
- `par_err` output 1: sticky parity error. Present only with `IXC_SKID_PARITY_EN`.
- `par_err_cnt` output 8: saturating error count. Present only with `IXC_SKID_PARITY_EN`.

## Operation
- Storage:
  - Main register `m_data`, which drives `out_data`.
  - Skid register `s_data`.
- Handshakes:
  - Input accept = `in_valid & in_ready`.
  - Output accept = `out_valid & out_ready`.
- State machine, state encoded as `occ`:
  - EMPTY (0):
    - Accept: load `m_data` and go to ONE.
  - ONE (1):
    - Accept with no pop: load `s_data` and go to TWO.
    - Pop with no accept: go to EMPTY.
    - Accept and pop together: load `m_data` and stay in ONE.
  - TWO (2):
    - `in_ready`=0, so no accept is possible.
    - Pop: `m_data` <= `s_data` and go to ONE.
- Outputs:
  - `out_valid` = (occ != 0).
  - `in_ready` is registered and equals (next occ != 2).
- Ordering is strict FIFO. No word is dropped or duplicated.
- `in_valid` asserted while `in_ready`=0 has no effect. The producer must hold `in_data` until it is accepted.
- Data registers are not reset-cleared beyond the value listed below. Payload bits pass through unmodified, with no width conversion.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `occ`=0, `out_data`=0.
  - `par_err`=0, `par_err_cnt`=0.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/clock sustained while `out_ready`=1.
- Back-pressure: `out_ready` low for k≥2 cycles fills both entries. `in_ready` drops the cycle after the second accept.
- Release: the first pop from TWO raises `in_ready` on the following cycle.
- Reset asserted mid-transfer: all held words are discarded immediately (asynchronously). Outputs take their reset values without waiting for a clock.
- `out_ready` with `out_valid`=0 is ignored.

## Configuration
- Macro: `IXC_SKID_PARITY_EN`.
- Defined:
  - On each input accept, XOR of `in_data` and `in_par` must be 0.
  - A mismatch sets `par_err` on the next edge; it stays set until reset.
  - A mismatch also increments `par_err_cnt`, which saturates at 255.
  - The word is still forwarded unchanged.
- Undefined: `in_par`, `par_err` and `par_err_cnt` ports and all parity logic are absent.

## Structure
- Shared package `ixc_skid_pkg`:
  - `occ_t` enum: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - `IXC_SKID_CNT_W`=8.
- Sub-module `ixc_skid_par_chk`:
  - Inputs: `DATA_W` bits plus the parity bit, and an accept strobe.
  - Outputs: sticky flag and saturating counter.
  - Instantiated only under the macro.
- Top-level wiring: `ixc_skid_stage.out_data` drives `ixc_assign_<DATA_W>.R`.

## Test plan
- Reset release, idle: `in_ready`=1, `out_valid`=0, `occ`=0. Assert `rst_n`=0 mid-stream: outputs return to these values with no clock edge.
- Streaming, `out_ready`=1: push 0x1..0x10 back-to-back. Outputs appear in order one cycle later, and `occ` stays at 1.
- Stall: hold `out_ready`=0 and push A, B, C.
  - `in_ready`=0 after B, `occ`=2, C is held.
  - Release: A, B, C are output in order with no gaps.
- Simultaneous push/pop in ONE: `occ` stays 1 and `out_data` updates to the new word.
- Width boundary: push a word with only bit 262 set, then an all-ones word. Both are output bit-exact.
- Parity (macro on):
  - A bad `in_par` on word 3 sets `par_err` next cycle and `par_err_cnt`=1, and the word is still output.
  - 300 bad words leave `par_err_cnt`=255.

Source files
------------

// File: rtl/ixc_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module : ixc_skid_pkg
// Shared occupancy encoding and counter helpers for the ixc skid stage.
// Rev    : 1.0
// ============================================================================
package ixc_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int IXC_SKID_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [IXC_SKID_CNT_W-1:0] sat_inc(
        input logic [IXC_SKID_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage : ixc_skid_pkg
`default_nettype wire

// File: rtl/ixc_skid_par_chk.sv
`default_nettype none
// ============================================================================
// Module : ixc_skid_par_chk
// Even-parity checker on accepted words: sticky flag plus saturating counter.
// Rev    : 1.0
// ============================================================================
module ixc_skid_par_chk
    import ixc_skid_pkg::*;
#(
    parameter int DATA_W = 263
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         data,
    input  logic                      par,
    input  logic                      accept,
    output logic                      err,
    output logic [IXC_SKID_CNT_W-1:0] err_cnt
);

    logic                      w_mismatch;
    logic                      r_err;
    logic [IXC_SKID_CNT_W-1:0] r_err_cnt;

    assign w_mismatch = accept & ((^data) ^ par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_mismatch) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule : ixc_skid_par_chk
`default_nettype wire

// File: rtl/ixc_skid_stage.sv
`default_nettype none
// ============================================================================
// Module : ixc_skid_stage
// Two-entry registered valid/ready skid stage feeding the ixc_assign R bus.
// Optional parity checking enabled by the IXC_SKID_PARITY_EN macro.
// Rev    : 1.0
// ============================================================================
module ixc_skid_stage
    import ixc_skid_pkg::*;
#(
    parameter int DATA_W = 263
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef IXC_SKID_PARITY_EN
    ,
    input  logic                      in_par,
    output logic                      par_err,
    output logic [IXC_SKID_CNT_W-1:0] par_err_cnt
`endif
);

    occ_t              r_occ;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_s_data;

    logic w_push;
    logic w_pop;
    logic w_skid_load;

    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = (r_occ != EMPTY) & out_ready;
    assign w_skid_load = (r_occ == ONE) & w_push & ~w_pop;

    // in_ready is loaded with (next occupancy != TWO) alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= EMPTY;
            r_in_ready <= 1'b1;
            r_m_data   <= '0;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (w_push) begin
                        r_m_data <= in_data;
                        r_occ    <= ONE;
                    end
                    r_in_ready <= 1'b1;
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_m_data   <= in_data;
                        r_in_ready <= 1'b1;
                    end else if (w_push) begin
                        r_occ      <= TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_occ      <= EMPTY;
                        r_in_ready <= 1'b1;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_m_data   <= r_s_data;
                        r_occ      <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_occ      <= EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Skid entry holds only live data while occupancy is TWO; no reset needed.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_s_data <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_occ != EMPTY);
    assign out_data  = r_m_data;
    assign occ       = r_occ;

`ifdef IXC_SKID_PARITY_EN
    ixc_skid_par_chk #(
        .DATA_W (DATA_W)
    ) u_par_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (in_data),
        .par     (in_par),
        .accept  (w_push),
        .err     (par_err),
        .err_cnt (par_err_cnt)
    );
`endif

endmodule : ixc_skid_stage
`default_nettype wire

// File: tb/tb_ixc_skid_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ixc_skid_stage
// Self-checking bench for ixc_skid_stage against a queue-based FIFO model.
// Rev    : 1.0
// ============================================================================
module tb_ixc_skid_stage;

    localparam int DATA_W = 263;
    typedef logic [DATA_W-1:0] word_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  in_valid = 1'b0;
    logic  in_ready;
    word_t in_data = '0;
    logic  out_valid;
    logic  out_ready = 1'b0;
    word_t out_data;
    logic [1:0] occ;
`ifdef IXC_SKID_PARITY_EN
    logic       in_par;
    logic       bad_par = 1'b0;
    logic       par_err;
    logic [7:0] par_err_cnt;
    always @* in_par = (^in_data) ^ bad_par;
`endif

    always #5 clk = ~clk;

    ixc_skid_stage #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
`ifdef IXC_SKID_PARITY_EN
        ,
        .in_par      (in_par),
        .par_err     (par_err),
        .par_err_cnt (par_err_cnt)
`endif
    );

    // Reference model: a FIFO of capacity two plus parity bookkeeping.
    word_t q[$];
    word_t exp_q[$];
    word_t got_q[$];
    bit    last_push;
    bit    m_err;
    int    m_cnt;
    int    tests = 0;
    int    fails = 0;

    function automatic word_t rand_word();
        word_t w;
        for (int b = 0; b < DATA_W; b++) w[b] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    // Advance one clock; the model decides acceptance from its own occupancy.
    task automatic cycle();
        bit push, pop;
        pop  = (q.size() != 0) && out_ready;
        push = in_valid && (q.size() < 2 || (q.size() == 1 && pop)) && (q.size() < 2);
        if (pop) begin
            exp_q.push_back(q.pop_front());
            got_q.push_back(out_data);
        end
        if (push) begin
            q.push_back(in_data);
`ifdef IXC_SKID_PARITY_EN
            if (in_par !== ^in_data) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
`endif
        end
        last_push = push;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        tests++; if (occ !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occ); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = word_t'(k);
            cycle();
            tests++; if (occ !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d]: got %0d expected 1", k, occ); end
            tests++; if (out_data !== word_t'(k)) begin fails++; $display("FAIL stream_data[%0d]: got %0h expected %0h", k, out_data, k); end
        end
        in_valid = 1'b0;
        cycle();
        tests++; if (out_valid !== 1'b0 || occ !== 2'd0) begin fails++; $display("FAIL stream_drain: got valid %0b occ %0d expected 0 0", out_valid, occ); end
        while (exp_q.size() != 0) begin
            word_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL stream_order: got %0h expected %0h", g, e); end
        end
    endtask

    task automatic test_stall();
        word_t a, b, c;
        int    guard;
        a = rand_word(); b = rand_word(); c = rand_word();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        cycle();
        tests++; if (occ !== 2'd1 || in_ready !== 1'b1) begin fails++; $display("FAIL stall_after_a: got occ %0d rdy %0b expected 1 1", occ, in_ready); end
        in_data = b;
        cycle();
        tests++; if (occ !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL stall_after_b: got occ %0d rdy %0b expected 2 0", occ, in_ready); end
        in_data = c;
        repeat (3) cycle();
        tests++; if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== a) begin fails++; $display("FAIL stall_hold: got occ %0d rdy %0b data %0h expected 2 0 %0h", occ, in_ready, out_data, a); end
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 || in_valid) begin
            cycle();
            if (last_push) in_valid = 1'b0;
            tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL stall_gap: got valid %0b expected %0b", out_valid, q.size() != 0); end
            guard++;
            if (guard > 10) begin
                tests++; fails++; $display("FAIL stall_timeout: got %0d cycles expected at most 10", guard);
                break;
            end
        end
        tests++; if (exp_q.size() != 3) begin fails++; $display("FAIL stall_count: got %0d expected 3", exp_q.size()); end
        tests++; if (exp_q.size() == 3 && (exp_q[0] !== a || exp_q[1] !== b || exp_q[2] !== c)) begin fails++; $display("FAIL stall_model_order: got %0h expected %0h", exp_q[0], a); end
        while (exp_q.size() != 0) begin
            word_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL stall_order: got %0h expected %0h", g, e); end
        end
    endtask

    task automatic test_simultaneous();
        word_t x, y;
        x = rand_word(); y = rand_word();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = x;
        cycle();
        out_ready = 1'b1;
        in_data   = y;
        cycle();
        tests++; if (occ !== 2'd1) begin fails++; $display("FAIL simul_occ: got %0d expected 1", occ); end
        tests++; if (out_data !== y) begin fails++; $display("FAIL simul_data: got %0h expected %0h", out_data, y); end
        tests++; if (got_q.size() != 1 || got_q[0] !== x) begin fails++; $display("FAIL simul_pop: got %0h expected %0h", got_q.size() ? got_q[0] : word_t'('x), x); end
        in_valid = 1'b0;
        cycle();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_width();
        word_t w1, w2;
        w1 = '0; w1[DATA_W-1] = 1'b1;
        w2 = '1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w1;
        cycle();
        tests++; if (out_data !== w1) begin fails++; $display("FAIL width_msb: got %0h expected %0h", out_data, w1); end
        in_data = w2;
        cycle();
        tests++; if (out_data !== w2) begin fails++; $display("FAIL width_ones: got %0h expected %0h", out_data, w2); end
        in_valid = 1'b0;
        cycle();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        int guard;
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_push) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_word();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            tests++;
            if (occ !== 2'(q.size()) || in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)
                || (q.size() != 0 && out_data !== q[0])) begin
                fails++;
                $display("FAIL random_state[%0d]: got occ %0d rdy %0b vld %0b expected occ %0d", i, occ, in_ready, out_valid, q.size());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 5) begin cycle(); guard++; end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL random_drain: got valid %0b expected 0", out_valid); end
        while (exp_q.size() != 0) begin
            word_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL random_order: got %0h expected %0h", g, e); end
        end
    endtask

`ifdef IXC_SKID_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = word_t'(k * 7);
            bad_par  = (k == 3);
            cycle();
            tests++; if (par_err !== m_err) begin fails++; $display("FAIL par_flag[%0d]: got %0b expected %0b", k, par_err, m_err); end
            tests++; if (par_err_cnt !== 8'(m_cnt)) begin fails++; $display("FAIL par_cnt[%0d]: got %0d expected %0d", k, par_err_cnt, m_cnt); end
            tests++; if (out_data !== word_t'(k * 7)) begin fails++; $display("FAIL par_forward[%0d]: got %0h expected %0h", k, out_data, k * 7); end
        end
        tests++; if (par_err_cnt !== 8'd1) begin fails++; $display("FAIL par_single: got %0d expected 1", par_err_cnt); end
        bad_par = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_data = rand_word();
            cycle();
        end
        tests++; if (par_err_cnt !== 8'd255 || m_cnt != 255) begin fails++; $display("FAIL par_saturate: got %0d expected 255", par_err_cnt); end
        tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL par_sticky: got %0b expected 1", par_err); end
        bad_par  = 1'b0;
        in_valid = 1'b0;
        cycle();
        exp_q.delete(); got_q.delete();
    endtask
`endif

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_word();
        cycle();
        in_data = rand_word();
        cycle();
        in_valid = 1'b0;
        tests++; if (occ !== 2'd2) begin fails++; $display("FAIL areset_fill: got %0d expected 2", occ); end
        #2;
        rst_n = 1'b0;
        #1;
        q.delete(); exp_q.delete(); got_q.delete();
        m_err = 1'b0; m_cnt = 0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_in_ready: got %0b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid: got %0b expected 0", out_valid); end
        tests++; if (occ !== 2'd0) begin fails++; $display("FAIL areset_occ: got %0d expected 0", occ); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL areset_out_data: got %0h expected 0", out_data); end
`ifdef IXC_SKID_PARITY_EN
        tests++; if (par_err !== 1'b0 || par_err_cnt !== 8'd0) begin fails++; $display("FAIL areset_par: got %0b %0d expected 0 0", par_err, par_err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_err = 1'b0;
        m_cnt = 0;
        last_push = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_simultaneous();
        test_width();
        test_random();
`ifdef IXC_SKID_PARITY_EN
        test_parity();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ixc_skid_stage
`default_nettype wire
